// File: rtl/sdram_arb_pkg.sv
// Shared encodings for the SDRAM read/write/refresh arbiter: command types, FSM states, grants.
// Pure declarations; no timing or flow-control behaviour lives here.
package sdram_arb_pkg;

  localparam logic [1:0] CMD_REF = 2'b00;
  localparam logic [1:0] CMD_WR  = 2'b01;
  localparam logic [1:0] CMD_RD  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ISSUE     = 2'd1,
    ST_WAIT_DONE = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    GNT_NONE = 2'd0,
    GNT_REF  = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } grant_e;

endpackage

// File: rtl/sdram_rw_arbiter_if.sv
// Request/command bundle around the arbiter; master is the arbiter, slave its environment.
// Command channel is valid/ready; completion is a one-clock cmd_done pulse.
interface sdram_rw_arbiter_if #(
  parameter int ADDR_W = 22
);
  logic              cam_frame_start;
  logic              vga_frame_start;
  logic [1:0]        cam_bank;
  logic [1:0]        vga_bank;
  logic [9:0]        wr_fifo_level;
  logic [9:0]        rd_fifo_level;
  logic              cmd_valid;
  logic              cmd_ready;
  logic [1:0]        cmd_type;
  logic [1:0]        cmd_bank;
  logic [ADDR_W-1:0] cmd_addr;
  logic              cmd_done;
  logic [ADDR_W-1:0] wr_addr_o;
  logic              busy;

  modport master (
    input  cam_frame_start, vga_frame_start, cam_bank, vga_bank,
    input  wr_fifo_level, rd_fifo_level, cmd_ready, cmd_done,
    output cmd_valid, cmd_type, cmd_bank, cmd_addr, wr_addr_o, busy
  );

  modport slave (
    output cam_frame_start, vga_frame_start, cam_bank, vga_bank,
    output wr_fifo_level, rd_fifo_level, cmd_ready, cmd_done,
    input  cmd_valid, cmd_type, cmd_bank, cmd_addr, wr_addr_o, busy
  );
endinterface

// File: rtl/frame_addr_gen.sv
// Linear frame address stepping BURST_LEN per adv, wrapping at FRAME_WORDS; clr beats adv.
// One-clock update, no handshake of its own.
module frame_addr_gen #(
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int ADDR_W      = 22
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              adv_i,
  input  logic              clr_i,
  output logic [ADDR_W-1:0] addr_o
);

  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] addr_d;
  logic [ADDR_W-1:0] addr_inc;

  always_comb begin
    addr_inc = addr_q + ADDR_W'(BURST_LEN);
    addr_d   = addr_q;
    if (clr_i) begin
      addr_d = '0;
    end else if (adv_i) begin
      addr_d = (addr_inc == ADDR_W'(FRAME_WORDS)) ? '0 : addr_inc;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else begin
      addr_q <= addr_d;
    end
  end

  assign addr_o = addr_q;

endmodule

// File: rtl/sdram_rw_arbiter.sv
// Arbitrates refresh, camera-write and VGA-read bursts onto one SDRAM command port.
// Grant to cmd_valid is one clock; cmd_valid holds until cmd_ready, then waits for cmd_done.
module sdram_rw_arbiter
  import sdram_arb_pkg::*;
#(
  parameter int BURST_LEN   = 256,
  parameter int FRAME_WORDS = 307200,
  parameter int WR_THRESH   = 256,
  parameter int RD_THRESH   = 512,
  parameter int REF_PERIOD  = 1040,
  parameter int ADDR_W      = 22
) (
  input logic                clk,
  input logic                rst_133,
  sdram_rw_arbiter_if.master bus
);

  localparam int TIMER_W = $clog2(REF_PERIOD);

  state_e              state_q;
  grant_e              grant_q;
  grant_e              grant_d;
  logic                last_rd_q;
  logic [TIMER_W-1:0]  ref_timer_q;
  logic                ref_pend_q;
  logic                cmd_valid_q;
  logic [1:0]          cmd_type_q;
  logic [1:0]          cmd_bank_q;
  logic [ADDR_W-1:0]   cmd_addr_q;
  logic                busy_q;

  logic                wr_req;
  logic                rd_req;
  logic                timer_exp;
  logic                accept;
  logic                wr_adv;
  logic                rd_adv;
  logic [ADDR_W-1:0]   wr_addr;
  logic [ADDR_W-1:0]   rd_addr;

  always_comb begin
    wr_req    = 32'(bus.wr_fifo_level) >= WR_THRESH;
    rd_req    = 32'(bus.rd_fifo_level) <= RD_THRESH;
    timer_exp = ref_timer_q == TIMER_W'(REF_PERIOD - 1);
    accept    = (state_q == ST_ISSUE) && cmd_valid_q && bus.cmd_ready;
    wr_adv    = accept && (grant_q == GNT_WR);
    rd_adv    = accept && (grant_q == GNT_RD);

    // Refresh never touches last_rd_q, so the rd/wr alternation survives it.
    grant_d = GNT_NONE;
    if (ref_pend_q) begin
      grant_d = GNT_REF;
    end else if (wr_req && rd_req) begin
      grant_d = last_rd_q ? GNT_WR : GNT_RD;
    end else if (wr_req) begin
      grant_d = GNT_WR;
    end else if (rd_req) begin
      grant_d = GNT_RD;
    end
  end

  always_ff @(posedge clk or negedge rst_133) begin
    if (!rst_133) begin
      state_q     <= ST_IDLE;
      grant_q     <= GNT_NONE;
      last_rd_q   <= 1'b1;
      ref_timer_q <= '0;
      ref_pend_q  <= 1'b0;
      cmd_valid_q <= 1'b0;
      cmd_type_q  <= CMD_REF;
      cmd_bank_q  <= 2'd0;
      cmd_addr_q  <= '0;
      busy_q      <= 1'b0;
    end else begin
      ref_timer_q <= timer_exp ? '0 : ref_timer_q + 1'b1;
      if (timer_exp) begin
        ref_pend_q <= 1'b1;
      end else if (accept && (grant_q == GNT_REF)) begin
        ref_pend_q <= 1'b0;
      end

      case (state_q)
        ST_IDLE: begin
          if (grant_d != GNT_NONE) begin
            grant_q     <= grant_d;
            cmd_valid_q <= 1'b1;
            state_q     <= ST_ISSUE;
            case (grant_d)
              GNT_WR: begin
                cmd_type_q <= CMD_WR;
                cmd_bank_q <= bus.cam_bank;
                cmd_addr_q <= wr_addr;
                last_rd_q  <= 1'b0;
              end
              GNT_RD: begin
                cmd_type_q <= CMD_RD;
                cmd_bank_q <= bus.vga_bank;
                cmd_addr_q <= rd_addr;
                last_rd_q  <= 1'b1;
              end
              default: begin
                cmd_type_q <= CMD_REF;
                cmd_bank_q <= 2'd0;
                cmd_addr_q <= '0;
              end
            endcase
          end
        end
        ST_ISSUE: begin
          if (bus.cmd_ready) begin
            cmd_valid_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= ST_WAIT_DONE;
          end
        end
        ST_WAIT_DONE: begin
          if (bus.cmd_done) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  frame_addr_gen #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_wr_addr (
    .clk   (clk),
    .rst_n (rst_133),
    .adv_i (wr_adv),
    .clr_i (bus.cam_frame_start),
    .addr_o(wr_addr)
  );

  frame_addr_gen #(
    .BURST_LEN  (BURST_LEN),
    .FRAME_WORDS(FRAME_WORDS),
    .ADDR_W     (ADDR_W)
  ) u_rd_addr (
    .clk   (clk),
    .rst_n (rst_133),
    .adv_i (rd_adv),
    .clr_i (bus.vga_frame_start),
    .addr_o(rd_addr)
  );

  assign bus.cmd_valid = cmd_valid_q;
  assign bus.cmd_type  = cmd_type_q;
  assign bus.cmd_bank  = cmd_bank_q;
  assign bus.cmd_addr  = cmd_addr_q;
  assign bus.busy      = busy_q;
  assign bus.wr_addr_o = wr_addr;

endmodule

// File: tb/tb_sdram_rw_arbiter.sv
// Scoreboarded bench: directed stimulus queues expected commands, a monitor checks each accepted one.
module tb_sdram_rw_arbiter;
  import sdram_arb_pkg::*;

  typedef struct packed {
    logic [1:0]  typ;
    logic [1:0]  bank;
    logic [21:0] addr;
  } exp_t;

  logic clk;
  logic rst_133;
  sdram_rw_arbiter_if #(.ADDR_W(22)) bus ();

  sdram_rw_arbiter #(
    .BURST_LEN(256), .FRAME_WORDS(307200), .WR_THRESH(256),
    .RD_THRESH(512), .REF_PERIOD(1040), .ADDR_W(22)
  ) dut (
    .clk    (clk),
    .rst_133(rst_133),
    .bus    (bus)
  );

  exp_t exp_q[$];
  int   vectors     = 0;
  int   miscompares = 0;
  int   acc_cnt     = 0;
  bit   done_hold   = 1'b1;
  bit   ref_in_queue = 1'b1;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached, vectors=%0d miscompares=%0d", vectors, miscompares);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  task automatic push(input logic [1:0] t, input logic [1:0] b, input logic [21:0] a);
    exp_t e;
    e.typ  = t;
    e.bank = b;
    e.addr = a;
    exp_q.push_back(e);
  endtask

  // Returns with the DUT parked in WAIT_DONE of command n (cmd_done withheld).
  task automatic wait_acc(input int n, input int budget);
    int c = 0;
    while (acc_cnt < n && c < budget) begin
      @(posedge clk); #1;
      c++;
    end
    done_hold = 1'b1;
    check("accepted-command count", 32'(acc_cnt), 32'(n));
  endtask

  task automatic wait_valid(input int budget);
    int c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!bus.cmd_valid && c < budget);
    check("cmd_valid raised", 32'(bus.cmd_valid), 32'd1);
  endtask

  // Controller model: answers each busy command with cmd_done unless held.
  initial begin
    bus.cmd_done = 1'b0;
    forever begin
      @(posedge clk); #2;
      if (bus.cmd_done) bus.cmd_done = 1'b0;
      else if (bus.busy && !done_hold) bus.cmd_done = 1'b1;
    end
  end

  // Monitor: every accepted command is compared against the head of the queue.
  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst_133 && bus.cmd_valid && bus.cmd_ready) begin
        if (bus.cmd_type == CMD_REF && !ref_in_queue) begin
          check("background refresh bank", 32'(bus.cmd_bank), 32'd0);
          check("background refresh addr", 32'(bus.cmd_addr), 32'd0);
        end else if (exp_q.size() == 0) begin
          check("unexpected command type", 32'(bus.cmd_type), 32'hFFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("cmd_type", 32'(bus.cmd_type), 32'(e.typ));
          check("cmd_bank", 32'(bus.cmd_bank), 32'(e.bank));
          check("cmd_addr", 32'(bus.cmd_addr), 32'(e.addr));
          acc_cnt++;
        end
      end
    end
  end

  initial begin : stim
    int base;
    bit stable;
    rst_133             = 1'b0;
    bus.cam_frame_start = 1'b0;
    bus.vga_frame_start = 1'b0;
    bus.cam_bank        = 2'd2;
    bus.vga_bank        = 2'd1;
    bus.wr_fifo_level   = 10'd300;
    bus.rd_fifo_level   = 10'd600;
    bus.cmd_ready       = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("reset cmd_type",  32'(bus.cmd_type),  32'd0);
    check("reset cmd_bank",  32'(bus.cmd_bank),  32'd0);
    check("reset cmd_addr",  32'(bus.cmd_addr),  32'd0);
    check("reset busy",      32'(bus.busy),      32'd0);
    check("reset wr_addr_o", 32'(bus.wr_addr_o), 32'd0);

    // Writes only, then both requesters alternating starting with a read.
    push(CMD_WR, 2'd2, 22'd0);
    push(CMD_WR, 2'd2, 22'd256);
    @(posedge clk); #1;
    rst_133 = 1'b1;
    wait_acc(1, 50);
    done_hold = 1'b0;
    wait_acc(2, 50);
    check("wr_addr_o after two writes", 32'(bus.wr_addr_o), 32'd512);
    bus.rd_fifo_level = 10'd100;
    push(CMD_RD, 2'd1, 22'd0);
    push(CMD_WR, 2'd2, 22'd512);
    push(CMD_RD, 2'd1, 22'd256);
    push(CMD_WR, 2'd2, 22'd768);
    done_hold = 1'b0;
    wait_acc(6, 100);
    check("wr_addr_o after four writes", 32'(bus.wr_addr_o), 32'd1024);

    // Refresh expiry while a write sits in WAIT_DONE.
    repeat (1100) @(posedge clk);
    #1;
    check("busy held across timer expiry", 32'(bus.busy), 32'd1);
    push(CMD_REF, 2'd0, 22'd0);
    push(CMD_RD, 2'd1, 22'd512);
    done_hold = 1'b0;
    wait_acc(8, 100);
    push(CMD_WR, 2'd2, 22'd1024);
    done_hold = 1'b0;
    wait_acc(9, 100);
    check("queue drained before frame run", 32'(exp_q.size()), 32'd0);

    // Full frame of writes with wrap, then a mid-frame camera restart.
    @(posedge clk); #1;
    rst_133 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.cam_bank      = 2'd3;
    bus.wr_fifo_level = 10'd300;
    bus.rd_fifo_level = 10'd600;
    ref_in_queue      = 1'b0;
    base = acc_cnt;
    for (int i = 0; i < 1201; i++) push(CMD_WR, 2'd3, 22'((i * 256) % 307200));
    done_hold = 1'b0;
    rst_133   = 1'b1;
    wait_acc(base + 1201, 20000);
    check("wr_addr_o after frame wrap", 32'(bus.wr_addr_o), 32'd256);
    push(CMD_WR, 2'd3, 22'd256);
    push(CMD_WR, 2'd3, 22'd512);
    done_hold = 1'b0;
    wait_acc(base + 1203, 100);
    check("wr_addr_o mid-frame", 32'(bus.wr_addr_o), 32'd768);
    @(posedge clk); #1;
    bus.cam_frame_start = 1'b1;
    @(posedge clk); #1;
    bus.cam_frame_start = 1'b0;
    check("wr_addr_o after cam_frame_start", 32'(bus.wr_addr_o), 32'd0);
    push(CMD_WR, 2'd3, 22'd0);
    done_hold = 1'b0;
    wait_acc(base + 1204, 100);
    check("wr_addr_o after restarted write", 32'(bus.wr_addr_o), 32'd256);

    // Stalled ISSUE, frame start inside the stall, and frame start on the accept edge.
    @(posedge clk); #1;
    rst_133 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.wr_fifo_level = 10'd0;
    bus.rd_fifo_level = 10'd100;
    bus.vga_bank      = 2'd1;
    bus.cmd_ready     = 1'b1;
    ref_in_queue      = 1'b1;
    base = acc_cnt;
    push(CMD_RD, 2'd1, 22'd0);
    done_hold = 1'b0;
    rst_133   = 1'b1;
    wait_acc(base + 1, 50);
    push(CMD_RD, 2'd1, 22'd256);
    bus.cmd_ready = 1'b0;
    done_hold = 1'b0;
    wait_valid(50);
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.vga_frame_start = (i == 5);
      if (i == 5) bus.vga_bank = 2'd2;
      @(negedge clk);
      if (!(bus.cmd_valid === 1'b1 && bus.cmd_type === CMD_RD &&
            bus.cmd_bank === 2'd1 && bus.cmd_addr === 22'd256)) stable = 1'b0;
    end
    check("ISSUE fields stable while stalled", 32'(stable), 32'd1);
    @(posedge clk); #1;
    bus.cmd_ready = 1'b1;
    wait_acc(base + 2, 50);
    push(CMD_RD, 2'd2, 22'd256);
    bus.cmd_ready = 1'b0;
    done_hold = 1'b0;
    wait_valid(50);
    done_hold = 1'b1;
    @(posedge clk); #1;
    bus.cmd_ready       = 1'b1;
    bus.vga_frame_start = 1'b1;
    @(posedge clk); #1;
    bus.vga_frame_start = 1'b0;
    wait_acc(base + 3, 50);
    push(CMD_RD, 2'd2, 22'd0);
    done_hold = 1'b0;
    wait_acc(base + 4, 50);

    // Asynchronous reset in WAIT_DONE, then fresh-reset behaviour.
    check("busy before mid-command reset", 32'(bus.busy), 32'd1);
    @(posedge clk); #3;
    rst_133 = 1'b0;
    #1;
    check("async reset cmd_valid", 32'(bus.cmd_valid), 32'd0);
    check("async reset busy",      32'(bus.busy),      32'd0);
    check("async reset cmd_bank",  32'(bus.cmd_bank),  32'd0);
    check("async reset wr_addr_o", 32'(bus.wr_addr_o), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    bus.wr_fifo_level = 10'd300;
    bus.rd_fifo_level = 10'd600;
    bus.cam_bank      = 2'd1;
    push(CMD_WR, 2'd1, 22'd0);
    rst_133 = 1'b1;
    wait_acc(base + 5, 50);
    bus.rd_fifo_level = 10'd100;
    push(CMD_RD, 2'd2, 22'd0);
    done_hold = 1'b0;
    wait_acc(base + 6, 50);
    check("queue drained at end", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
